// File: rtl/muldiv_unit.sv
// Iterative WIDTH-bit MULT/MULTU/DIV/DIVU unit writing architectural HI/LO; one bit per cycle.
// Optional macro MULDIV_EARLY_TERM_EN: multiplies finish once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             flush,
    input  logic             hilo_we,
    input  logic             hilo_sel,
    input  logic [WIDTH-1:0] hilo_wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

`ifdef MULDIV_EARLY_TERM_EN
    localparam bit EARLY_TERM = 1'b1;
`else
    localparam bit EARLY_TERM = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t             state_reg;
    logic [CW-1:0]      cnt_reg;
    logic               is_div_reg;
    logic               sign_a_reg;
    logic               sign_b_reg;
    logic               dbz_pend_reg;
    logic [2*WIDTH-1:0] acc_reg;     // mult: product; div: {remainder, dividend/quotient}
    logic [2*WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0]   opb_reg;     // mult: multiplier (shifts right); div: divisor
    logic               busy_reg;
    logic               done_reg;
    logic               div_by_zero_reg;
    logic [WIDTH-1:0]   hi_reg;
    logic [WIDTH-1:0]   lo_reg;

    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [2*WIDTH-1:0] mul_acc_next;
    logic [WIDTH:0]     div_shift;
    logic               div_ok;
    logic [WIDTH-1:0]   rem_next;
    logic [2*WIDTH-1:0] div_acc_next;
    logic               run_last;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        a_neg = ~op[0] & operand_a[WIDTH-1];
        b_neg = ~op[0] & operand_b[WIDTH-1];
        a_mag = a_neg ? -operand_a : operand_a;
        b_mag = b_neg ? -operand_b : operand_b;

        mul_acc_next = acc_reg + (opb_reg[0] ? mcand_reg : '0);

        // Partial remainder stays below the divisor, so the difference fits in WIDTH bits.
        div_shift    = {acc_reg[2*WIDTH-1:WIDTH], acc_reg[WIDTH-1]};
        div_ok       = (div_shift >= {1'b0, opb_reg});
        rem_next     = div_ok ? (div_shift[WIDTH-1:0] - opb_reg) : div_shift[WIDTH-1:0];
        div_acc_next = {rem_next, acc_reg[WIDTH-2:0], div_ok};

        run_last = (cnt_reg == '0) ||
                   (EARLY_TERM && !is_div_reg && (opb_reg[WIDTH-1:1] == '0));

        prod_fix = (sign_a_reg ^ sign_b_reg) ? -acc_reg : acc_reg;
        quo_fix  = (sign_a_reg ^ sign_b_reg) ? -acc_reg[WIDTH-1:0] : acc_reg[WIDTH-1:0];
        rem_fix  = sign_a_reg ? -acc_reg[2*WIDTH-1:WIDTH] : acc_reg[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg       <= IDLE;
            cnt_reg         <= '0;
            is_div_reg      <= 1'b0;
            sign_a_reg      <= 1'b0;
            sign_b_reg      <= 1'b0;
            dbz_pend_reg    <= 1'b0;
            acc_reg         <= '0;
            mcand_reg       <= '0;
            opb_reg         <= '0;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            div_by_zero_reg <= 1'b0;
            hi_reg          <= '0;
            lo_reg          <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start && !flush) begin
                        is_div_reg      <= op[1];
                        sign_a_reg      <= a_neg;
                        sign_b_reg      <= b_neg;
                        cnt_reg         <= CW'(WIDTH - 1);
                        div_by_zero_reg <= 1'b0;
                        dbz_pend_reg    <= 1'b0;
                        busy_reg        <= 1'b1;
                        opb_reg         <= b_mag;
                        if (op[1] && operand_b == '0) begin
                            // Result preloaded so FIX writes LO=all ones, HI=operand_a unaltered.
                            acc_reg      <= {operand_a, {WIDTH{1'b1}}};
                            sign_a_reg   <= 1'b0;
                            sign_b_reg   <= 1'b0;
                            dbz_pend_reg <= 1'b1;
                            state_reg    <= FIX;
                        end else if (op[1]) begin
                            acc_reg   <= {{WIDTH{1'b0}}, a_mag};
                            state_reg <= RUN;
                        end else begin
                            acc_reg   <= '0;
                            mcand_reg <= {{WIDTH{1'b0}}, a_mag};
                            state_reg <= (EARLY_TERM && b_mag == '0) ? FIX : RUN;
                        end
                    end else if (hilo_we && !start) begin
                        if (hilo_sel) hi_reg <= hilo_wdata;
                        else          lo_reg <= hilo_wdata;
                    end
                end
                RUN: begin
                    if (flush) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        if (is_div_reg) begin
                            acc_reg <= div_acc_next;
                        end else begin
                            acc_reg   <= mul_acc_next;
                            mcand_reg <= mcand_reg << 1;
                            opb_reg   <= opb_reg >> 1;
                        end
                        cnt_reg <= cnt_reg - CW'(1);
                        if (run_last) state_reg <= FIX;
                    end
                end
                FIX: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                    if (!flush) begin
                        if (is_div_reg) begin
                            lo_reg <= quo_fix;
                            hi_reg <= rem_fix;
                        end else begin
                            lo_reg <= prod_fix[WIDTH-1:0];
                            hi_reg <= prod_fix[2*WIDTH-1:WIDTH];
                        end
                        div_by_zero_reg <= dbz_pend_reg;
                        done_reg        <= 1'b1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign div_by_zero = div_by_zero_reg;
    assign hi          = hi_reg;
    assign lo          = lo_reg;
endmodule
